dmem_arbiter: RTL and testbench

- Shares the single data memory between two requesters: the pipeline MEM stage (CPU port) and a DMA/loader port.
- Inserts a configurable number of memory wait states.
- Stalls the pipeline while the CPU access is incomplete or the memory is owned by DMA.
- Sits between the MEM stage and the data memory; the CPU port connects to the stage's memory-control and address/data signals.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage CPU port and a DMA/loader port.
// Inserts WAIT_STATES extra cycles per access and stalls the CPU until its own access ends.
module dmem_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_done,
    output logic [31:0] dma_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] WS_C = 4'(WAIT_STATES);
    localparam logic [3:0] SM_C = 4'(STARVE_MAX);

    state_t      state_r, state_s;
    owner_t      owner_r, owner_s, cur_owner_s;
    logic [3:0]  cnt_r, cnt_s, cur_cnt_s;
    logic [3:0]  starve_r, starve_s;
    logic        cpu_req_s, final_s, active_s, we_s;
    logic [31:0] addr_s, wdata_s;

    // Arbitration, access sequencing and next-state computation.
    always_comb begin
        cpu_req_s   = cpu_rd | cpu_wr;
        cur_owner_s = OWN_NONE;
        cur_cnt_s   = 4'd0;
        we_s        = 1'b0;
        addr_s      = 32'd0;
        wdata_s     = 32'd0;
        active_s    = 1'b0;
        state_s     = state_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        starve_s    = starve_r;

        if (state_r == ST_IDLE) begin
            cur_cnt_s = 4'd0;
            if (dma_req && (!cpu_req_s || (starve_r == SM_C))) begin
                cur_owner_s = OWN_DMA;
            end else if (cpu_req_s) begin
                cur_owner_s = OWN_CPU;
            end else begin
                cur_owner_s = OWN_NONE;
            end
        end else begin
            cur_cnt_s   = cnt_r;
            cur_owner_s = owner_r;
        end

        // Simultaneous rd and wr is illegal; cpu_wr alone decides direction so it acts as a write.
        case (cur_owner_s)
            OWN_CPU: begin
                active_s = 1'b1;
                we_s     = cpu_wr;
                addr_s   = cpu_addr;
                wdata_s  = cpu_wdata;
            end
            OWN_DMA: begin
                active_s = 1'b1;
                we_s     = dma_we;
                addr_s   = dma_addr;
                wdata_s  = dma_wdata;
            end
            default: begin
                active_s = 1'b0;
                we_s     = 1'b0;
                addr_s   = 32'd0;
                wdata_s  = 32'd0;
            end
        endcase

        final_s = active_s && (cur_cnt_s == WS_C);

        if (!active_s) begin
            state_s = ST_IDLE;
            owner_s = OWN_NONE;
            cnt_s   = 4'd0;
        end else if (final_s) begin
            state_s = ST_IDLE;
            owner_s = OWN_NONE;
            cnt_s   = 4'd0;
        end else begin
            state_s = ST_BUSY;
            owner_s = cur_owner_s;
            cnt_s   = cur_cnt_s + 4'd1;
        end

        if ((state_r == ST_IDLE) && dma_req && (cur_owner_s == OWN_CPU) && (starve_r != SM_C)) begin
            starve_s = starve_r + 4'd1;
        end else if ((cur_owner_s == OWN_DMA) && final_s) begin
            starve_s = 4'd0;
        end else begin
            starve_s = starve_r;
        end
    end

    // State, owner, wait counter and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= OWN_NONE;
            cnt_r    <= 4'd0;
            starve_r <= 4'd0;
        end else begin
            state_r  <= state_s;
            owner_r  <= owner_s;
            cnt_r    <= cnt_s;
            starve_r <= starve_s;
        end
    end

    // Outputs are combinational and forced low while reset is held, so an aborted write never pulses.
    assign mem_read  = rst_n & active_s & ~we_s;
    assign mem_write = rst_n & active_s & we_s & final_s;
    assign mem_addr  = rst_n ? addr_s : 32'd0;
    assign mem_wdata = rst_n ? wdata_s : 32'd0;
    assign cpu_stall = rst_n & cpu_req_s & ~((cur_owner_s == OWN_CPU) & final_s);
    assign cpu_rdata = (rst_n && (cur_owner_s == OWN_CPU)) ? mem_rdata : 32'd0;
    assign dma_done  = rst_n & (cur_owner_s == OWN_DMA) & final_s;
    assign dma_rdata = (rst_n && (cur_owner_s == OWN_DMA) && final_s) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: four instances (WAIT_STATES 0..3) share stimulus,
// each backed by its own small memory model; read data is scoreboarded through a queue.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = 32'd0, dma_wdata = 32'd0;

    logic [31:0] cpu_rdata [4];
    logic        cpu_stall [4];
    logic        dma_done  [4];
    logic [31:0] dma_rdata [4];
    logic        mem_read  [4];
    logic        mem_write [4];
    logic [31:0] mem_addr  [4];
    logic [31:0] mem_wdata [4];
    logic [31:0] mem_rdata [4];

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [31:0] mem [64];

        dmem_arbiter #(.WAIT_STATES(g), .STARVE_MAX(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cpu_rd    (cpu_rd),
            .cpu_wr    (cpu_wr),
            .cpu_addr  (cpu_addr),
            .cpu_wdata (cpu_wdata),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .dma_req   (dma_req),
            .dma_we    (dma_we),
            .dma_addr  (dma_addr),
            .dma_wdata (dma_wdata),
            .dma_done  (dma_done[g]),
            .dma_rdata (dma_rdata[g]),
            .mem_read  (mem_read[g]),
            .mem_write (mem_write[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );

        assign mem_rdata[g] = mem[mem_addr[g][7:2]];

        always @(posedge clk) begin
            if (mem_write[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
        end
    end

    task automatic apply_reset();
        cpu_rd = 1'b0; cpu_wr = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h14;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cpu_stall[i], dma_done[i], mem_read[i], mem_write[i]} !== 4'b0000 ||
                mem_addr[i] !== 32'd0 || mem_wdata[i] !== 32'd0 ||
                cpu_rdata[i] !== 32'd0 || dma_rdata[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d stall=%b done=%b rd=%b wr=%b addr=%h wdata=%h, required all zero",
                         i, cpu_stall[i], dma_done[i], mem_read[i], mem_write[i], mem_addr[i], mem_wdata[i]);
            end
        end
        apply_reset();
    endtask

    // One CPU access on instance idx; for reads the expected data goes through the scoreboard.
    task automatic cpu_access(input int idx, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input int exp_cycles);
        int cyc = 0;
        int wpulses = 0;
        bit done = 1'b0;
        logic [31:0] exp;
        cpu_wr = wr; cpu_rd = ~wr; cpu_addr = addr; cpu_wdata = data;
        if (!wr) exp_q.push_back(data);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_write[idx]) wpulses++;
            if (!wr) begin
                checks++;
                if (mem_read[idx] !== 1'b1) begin
                    errors++;
                    $display("FAIL mem_read_level inst=%0d cyc=%0d got=%b required=1", idx, cyc, mem_read[idx]);
                end
            end
            if (!cpu_stall[idx]) begin
                done = 1'b1;
                if (!wr) begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (cpu_rdata[idx] !== exp) begin
                        errors++;
                        $display("FAIL cpu_rdata inst=%0d addr=%h got=%h required=%h", idx, addr, cpu_rdata[idx], exp);
                    end
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!done || cyc != exp_cycles) begin
            errors++;
            $display("FAIL access_latency inst=%0d wr=%b got=%0d cycles (done=%b) required=%0d", idx, wr, cyc, done, exp_cycles);
        end
        checks++;
        if (wpulses != (wr ? 1 : 0)) begin
            errors++;
            $display("FAIL write_pulses inst=%0d got=%0d required=%0d", idx, wpulses, wr ? 1 : 0);
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic test_zero_wait();
        apply_reset();
        cpu_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1);
        cpu_access(0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1);
    endtask

    task automatic test_wait_states();
        apply_reset();
        cpu_access(2, 1'b1, 32'h20, 32'hCAFE_0020, 3);
        cpu_access(2, 1'b0, 32'h20, 32'hCAFE_0020, 3);
    endtask

    task automatic test_dma_write();
        apply_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234_5678;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (dma_done[1] !== (c == 2) || mem_write[1] !== (c == 2)) begin
                errors++;
                $display("FAIL dma_write_timing cyc=%0d done=%b wr=%b required=%b", c, dma_done[1], mem_write[1], c == 2);
            end
            @(posedge clk); #1;
        end
        dma_req = 1'b0;
        cpu_access(1, 1'b0, 32'h40, 32'h1234_5678, 2);
    endtask

    task automatic test_starvation();
        logic exp_done;
        apply_reset();
        cpu_rd = 1'b1; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        for (int c = 1; c <= 10; c++) begin
            exp_done = (c == 5) || (c == 10);
            @(negedge clk);
            checks++;
            if (dma_done[0] !== exp_done || cpu_stall[0] !== exp_done) begin
                errors++;
                $display("FAIL starve_arb cyc=%0d done=%b stall=%b required=%b", c, dma_done[0], cpu_stall[0], exp_done);
            end
            if (exp_done) begin
                checks++;
                if (dma_rdata[0] !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL dma_rdata cyc=%0d got=%h required=%h", c, dma_rdata[0], 32'hDEAD_BEEF);
                end
            end else begin
                exp_q.push_back(32'hDEAD_BEEF);
                checks++;
                if (cpu_rdata[0] !== exp_q.pop_front()) begin
                    errors++;
                    $display("FAIL starve_cpu_rdata cyc=%0d got=%h required=%h", c, cpu_rdata[0], 32'hDEAD_BEEF);
                end
            end
            @(posedge clk); #1;
        end
        cpu_rd = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_dma_then_cpu();
        logic exp_stall, exp_done, exp_wr, exp_rd;
        int wpulses = 0;
        apply_reset();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin cpu_wr = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h0BAD_F00D; end
            exp_stall = (c >= 2) && (c <= 5);
            exp_done  = (c == 3);
            exp_wr    = (c == 6);
            exp_rd    = (c <= 3);
            @(negedge clk);
            if (mem_write[2]) wpulses++;
            checks++;
            if (cpu_stall[2] !== exp_stall || dma_done[2] !== exp_done ||
                mem_write[2] !== exp_wr || mem_read[2] !== exp_rd) begin
                errors++;
                $display("FAIL dma_cpu_seq cyc=%0d stall/done/wr/rd=%b%b%b%b required=%b%b%b%b", c,
                         cpu_stall[2], dma_done[2], mem_write[2], mem_read[2], exp_stall, exp_done, exp_wr, exp_rd);
            end
            if (c == 3) begin
                checks++;
                if (dma_rdata[2] !== 32'hCAFE_0020) begin
                    errors++;
                    $display("FAIL dma_read_data got=%h required=%h", dma_rdata[2], 32'hCAFE_0020);
                end
            end
            if (c == 6) begin
                checks++;
                if (mem_addr[2] !== 32'h30 || mem_wdata[2] !== 32'h0BAD_F00D) begin
                    errors++;
                    $display("FAIL cpu_write_bus addr=%h data=%h required=%h/%h", mem_addr[2], mem_wdata[2], 32'h30, 32'h0BAD_F00D);
                end
            end
            @(posedge clk); #1;
            if (c == 3) dma_req = 1'b0;
        end
        cpu_wr = 1'b0;
        checks++;
        if (wpulses != 1) begin
            errors++;
            $display("FAIL dma_cpu_write_pulses got=%0d required=1", wpulses);
        end
    endtask

    task automatic test_reset_mid_access();
        int wpulses = 0;
        apply_reset();
        cpu_wr = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (cpu_stall[3] !== 1'b1 || mem_write[3] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre stall=%b wr=%b required=1/0", cpu_stall[3], mem_write[3]);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_stall[3], mem_read[3], mem_write[3], dma_done[3]} !== 4'b0000 ||
            mem_addr[3] !== 32'd0 || mem_wdata[3] !== 32'd0) begin
            errors++;
            $display("FAIL midrst_outputs stall=%b rd=%b wr=%b addr=%h wdata=%h required all zero",
                     cpu_stall[3], mem_read[3], mem_write[3], mem_addr[3], mem_wdata[3]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_write[3]) wpulses++;
            if (c == 1) begin cpu_wr = 1'b0; rst_n = 1'b1; end
        end
        checks++;
        if (wpulses != 0) begin
            errors++;
            $display("FAIL midrst_write_pulses got=%0d required=0", wpulses);
        end
        @(posedge clk); #1;
        cpu_access(3, 1'b1, 32'h60, 32'h6666_0060, 4);
        cpu_access(3, 1'b0, 32'h60, 32'h6666_0060, 4);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_dma_write();
        test_starvation();
        test_dma_then_cpu();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
